// File: rtl/data_mem_access.sv
// Load/store initiator for a word-wide, 1-cycle-latency data memory: big-endian lane
// extraction with sign/zero extension, read-modify-write for sub-word stores, misalignment checks.
module data_mem_access #(
    parameter int WORD_IDX_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_adress,
    output logic [31:0] data_writedata,
    output logic        data_write,
    input  logic [31:0] data_readdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WAIT  = 2'd1,
        RMW_WAIT = 2'd2,
        RMW_WR   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t                state_r;
    logic [WORD_IDX_W-1:0] idx_r;
    logic [1:0]            off_r;
    logic [1:0]            size_r;
    logic                  signed_r;
    logic [15:0]           wdata_r;
    logic [31:0]           merge_r;
    logic                  err_s;
    logic                  addr_hi_unused_s;

    // Big-endian lane pick: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wd,
                                                input logic [1:0] off, input logic [1:0] size);
        logic [31:0] res;
        res = word;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    res[31:24] = wd[7:0];
                2'd1:    res[23:16] = wd[7:0];
                2'd2:    res[15:8]  = wd[7:0];
                default: res[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            res[15:0] = wd;
        end else begin
            res[31:16] = wd;
        end
        return res;
    endfunction

    assign addr_hi_unused_s = ^req_addr[31:WORD_IDX_W+2];

    // Illegal size or misaligned half/word request.
    always_comb begin
        err_s = 1'b0;
        if (req_size == 2'b11) begin
            err_s = 1'b1;
        end else if (req_size == SZ_HALF) begin
            err_s = req_addr[0];
        end else if (req_size == SZ_WORD) begin
            err_s = (req_addr[1:0] != 2'b00);
        end else begin
            err_s = 1'b0;
        end
    end

    // Memory-side drive: the read is issued straight from req_addr in the accept cycle.
    always_comb begin
        busy           = (state_r != IDLE);
        data_adress    = 32'd0;
        data_writedata = req_wdata;
        data_write     = 1'b0;
        if (state_r == IDLE) begin
            data_adress = {{(32-WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};
        end else begin
            data_adress = {{(32-WORD_IDX_W){1'b0}}, idx_r};
        end
        if (!rst_n) begin
            data_write = 1'b0;
        end else if (state_r == RMW_WR) begin
            data_write     = 1'b1;
            data_writedata = merge_r;
        end else if (state_r == IDLE) begin
            data_write = req && req_we && (req_size == SZ_WORD) && !err_s;
        end else begin
            data_write = 1'b0;
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            off_r      <= 2'd0;
            size_r     <= 2'd0;
            signed_r   <= 1'b0;
            wdata_r    <= 16'd0;
            merge_r    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req) begin
                        idx_r    <= req_addr[WORD_IDX_W+1:2];
                        off_r    <= req_addr[1:0];
                        size_r   <= req_size;
                        signed_r <= req_signed;
                        wdata_r  <= req_wdata[15:0];
                        if (err_s || (req_we && req_size == SZ_WORD)) begin
                            resp_valid <= 1'b1;
                            resp_err   <= err_s;
                            resp_rdata <= 32'd0;
                        end else if (!req_we) begin
                            state_r <= LD_WAIT;
                        end else begin
                            state_r <= RMW_WAIT;
                        end
                    end
                end
                LD_WAIT: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_extract(data_readdata, off_r, size_r, signed_r);
                    state_r    <= IDLE;
                end
                RMW_WAIT: begin
                    merge_r <= store_merge(data_readdata, wdata_r, off_r, size_r);
                    state_r <= RMW_WR;
                end
                RMW_WR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                    state_r    <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed self-checking bench for data_mem_access with a behavioural 1-cycle-latency memory.
module tb_data_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_adress;
    logic [31:0] data_writedata;
    logic        data_write;
    logic [31:0] data_readdata = 32'd0;

    logic [31:0] mem [0:63];
    int          wr_count = 0;
    int          checks = 0;
    int          errors = 0;

    data_mem_access #(.WORD_IDX_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .data_adress(data_adress), .data_writedata(data_writedata), .data_write(data_write),
        .data_readdata(data_readdata)
    );

    always #5 clk = ~clk;

    // Word memory: synchronous read, one cycle latency.
    always @(posedge clk) begin
        data_readdata <= mem[data_adress[5:0]];
        if (data_write) begin
            mem[data_adress[5:0]] <= data_writedata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
    endtask

    // Issues one request and waits (bounded) for its response; lat=99 means timeout.
    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata, output logic err);
        issue(we, size, sgn, addr, wdata);
        lat = 99; rdata = 32'hxxxxxxxx; err = 1'bx;
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            req = 1'b0;
            if (resp_valid === 1'b1) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({busy, resp_valid, resp_err, data_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {busy, resp_valid, resp_err, data_write});
        end
        checks++; if (resp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata got %h want 00000000", resp_rdata);
        end
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        checks++; if ({busy, resp_valid} !== 2'b00) begin
            errors++; $display("FAIL post_reset got %b want 00", {busy, resp_valid});
        end
    endtask

    task automatic test_word_rw();
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
        #1;
        checks++; if ({data_write, busy} !== 2'b10 || data_adress !== 32'h10 || data_writedata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_T got we=%b busy=%b adr=%h wd=%h want 1 0 10 deadbeef",
                               data_write, busy, data_adress, data_writedata);
        end
        next_cycle();
        req = 1'b0;
        checks++; if ({resp_valid, resp_err, busy} !== 3'b100 || mem[16] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL sw_T1 got v/e/b=%b mem=%h want 100 deadbeef", {resp_valid, resp_err, busy}, mem[16]);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        next_cycle();
        checks++; if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL sw_single_pulse got %b want 0", resp_valid);
        end
        req = 1'b0;
        checks++; if (busy !== 1'b1 || data_write !== 1'b0 || data_adress !== 32'h10) begin
            errors++; $display("FAIL lw_T1 got busy=%b we=%b adr=%h want 1 0 10", busy, data_write, data_adress);
        end
        next_cycle();
        checks++; if ({resp_valid, resp_err, busy} !== 3'b100 || resp_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL lw_T2 got v/e/b=%b rdata=%h want 100 deadbeef", {resp_valid, resp_err, busy}, resp_rdata);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [5]  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        sg [5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad [5]  = '{32'h40, 32'h40, 32'h42, 32'h42, 32'h40};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h00007F01, 32'h000080FF};
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h80FF7F01, lat, rd, er);
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rd, er);
            checks++; if (lat != 2 || er !== 1'b0 || rd !== exp[i]) begin
                errors++; $display("FAIL load_%0d got lat=%0d err=%b rdata=%h want 2 0 %h", i, lat, er, rd, exp[i]);
            end
        end
    endtask

    task automatic test_rmw();
        int lat; logic [31:0] rd; logic er; int wc;
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, lat, rd, er);
        wc = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA);
        #1;
        checks++; if ({data_write, busy} !== 2'b00) begin
            errors++; $display("FAIL sb_T got we/busy=%b want 00", {data_write, busy});
        end
        next_cycle();
        req = 1'b0;
        checks++; if ({busy, data_write, resp_valid} !== 3'b100) begin
            errors++; $display("FAIL sb_T1 got busy/we/v=%b want 100", {busy, data_write, resp_valid});
        end
        next_cycle();
        checks++; if ({busy, data_write, resp_valid} !== 3'b110 || data_adress !== 32'h10 || data_writedata !== 32'h11AA3344) begin
            errors++; $display("FAIL sb_T2 got b/we/v=%b adr=%h wd=%h want 110 10 11aa3344",
                               {busy, data_write, resp_valid}, data_adress, data_writedata);
        end
        next_cycle();
        checks++; if ({resp_valid, resp_err, busy} !== 3'b100 || mem[16] !== 32'h11AA3344 || wr_count != wc + 1) begin
            errors++; $display("FAIL sb_T3 got v/e/b=%b mem=%h writes=%0d want 100 11aa3344 %0d",
                               {resp_valid, resp_err, busy}, mem[16], wr_count - wc, 1);
        end
        run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000BEEF, lat, rd, er);
        checks++; if (lat != 3 || er !== 1'b0 || mem[16] !== 32'h11AABEEF) begin
            errors++; $display("FAIL sh_rmw got lat=%0d err=%b mem=%h want 3 0 11aabeef", lat, er, mem[16]);
        end
    endtask

    task automatic test_misalign();
        logic        we [3]  = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3]  = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3]  = '{32'h41, 32'h43, 32'h40};
        int lat; logic [31:0] rd; logic er; int wc;
        for (int i = 0; i < 3; i++) begin
            wc = wr_count;
            issue(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D);
            #1;
            checks++; if ({data_write, busy} !== 2'b00) begin
                errors++; $display("FAIL misalign_T_%0d got we/busy=%b want 00", i, {data_write, busy});
            end
            req = 1'b0;
            #1;
            run_req(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, lat, rd, er);
            checks++; if (lat != 1 || er !== 1'b1 || rd !== 32'd0 || wr_count != wc || mem[16] !== 32'h11AABEEF) begin
                errors++; $display("FAIL misalign_%0d got lat=%0d err=%b rdata=%h writes=%0d mem=%h want 1 1 0 0 11aabeef",
                                   i, lat, er, rd, wr_count - wc, mem[16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        run_req(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, lat, rd, er);
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h00000055);
        next_cycle();
        issue(1'b0, 2'b10, 1'b0, 32'h45, 32'hFFFFFFFF);
        checks++; if ({busy, resp_valid} !== 2'b10) begin
            errors++; $display("FAIL busy_T1 got busy/v=%b want 10", {busy, resp_valid});
        end
        next_cycle();
        req_addr = 32'h80;
        #1;
        checks++; if (data_write !== 1'b1 || data_adress !== 32'h10 || data_writedata !== 32'h55AABEEF) begin
            errors++; $display("FAIL busy_T2 got we=%b adr=%h wd=%h want 1 10 55aabeef", data_write, data_adress, data_writedata);
        end
        next_cycle();
        checks++; if ({resp_valid, busy} !== 2'b10 || data_adress !== 32'h20) begin
            errors++; $display("FAIL busy_T3 got v/busy=%b adr=%h want 10 20", {resp_valid, busy}, data_adress);
        end
        next_cycle();
        req = 1'b0;
        checks++; if ({resp_valid, busy} !== 2'b01) begin
            errors++; $display("FAIL busy_T4 got v/busy=%b want 01", {resp_valid, busy});
        end
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h12345678 || mem[16] !== 32'h55AABEEF) begin
            errors++; $display("FAIL busy_T5 got v=%b rdata=%h mem=%h want 1 12345678 55aabeef", resp_valid, resp_rdata, mem[16]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er; int wc;
        wc = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h00000000);
        next_cycle();
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, resp_valid, data_write} !== 3'b000) begin
            errors++; $display("FAIL rst_mid got busy/v/we=%b want 000", {busy, resp_valid, data_write});
        end
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        next_cycle();
        checks++; if ({busy, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'd0 || wr_count != wc || mem[16] !== 32'h55AABEEF) begin
            errors++; $display("FAIL rst_mid_after got b/v/e=%b rdata=%h writes=%0d mem=%h want 000 0 0 55aabeef",
                               {busy, resp_valid, resp_err}, resp_rdata, wr_count - wc, mem[16]);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er);
        checks++; if (lat != 2 || rd !== 32'h55AABEEF) begin
            errors++; $display("FAIL rst_mid_reload got lat=%0d rdata=%h want 2 55aabeef", lat, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        test_reset();
        test_word_rw();
        test_loads();
        test_rmw();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Initiator side of the CPU data-memory interface.
- Accepts one load/store request at a time from the execute/memory stage and issues word-wide accesses to the data memory.
- The data memory is word-indexed, reads synchronously with 1-cycle latency and writes whole words only, so this block handles the rest:
  - byte/halfword lane selection and sign/zero extension on loads;
  - read-modify-write for sub-word stores;
  - misalignment detection.

Parameters:
- WORD_IDX_W, 24, number of significant word-index bits driven on data_adress; upper bits are driven 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  1  request strobe; accepted when req=1 and busy=0.
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1=sign-extend, 0=zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- busy  out  1  high while a multi-cycle access is in flight; requests are ignored while high.
- resp_valid  out  1  one-cycle pulse on completion of every accepted request.
- resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request, valid with resp_valid.
- data_adress  out  32  word index to memory, {zeros, req_addr[WORD_IDX_W+1:2]}.
- data_writedata  out  32  full word to write.
- data_write  out  1  memory write enable.
- data_readdata  in  32  memory read data; valid the cycle after the address is presented.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0; internal address/merge registers=0.
  - data_write forced 0 while rst_n low.
  - Reset mid-access drops the access; no write is issued after release.
- Lane map is big-endian:
  - Byte offsets 0/1/2/3 map to [31:24]/[23:16]/[15:8]/[7:0].
  - Half offsets 0/2 map to [31:16]/[15:0].
- Error checks:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned or size 11: no memory access (data_write=0); resp_valid=1, resp_err=1, resp_rdata=0 at T+1 (T = accept cycle); busy stays 0.
- States: IDLE, LD_WAIT, RMW_WAIT, RMW_WR. busy = (state != IDLE).
- IDLE:
  - data_adress is driven combinationally from req_addr, so the read is issued in the accept cycle.
  - data_write=0 except for an aligned word store.
- Word store:
  - In accept cycle T: data_write=1, data_writedata=req_wdata. State stays IDLE.
  - resp_valid at T+1, err=0. busy never asserts.
- Load:
  - IDLE to LD_WAIT at T.
  - At T+1: data_adress holds the latched index; data_readdata is extracted/extended into resp_rdata; state returns to IDLE.
  - resp_valid at T+2. busy high during T+1 only. A new request can be accepted at T+2.
- Sub-word store:
  - IDLE to RMW_WAIT at T (read issued).
  - At T+1: merge the relevant lane(s) of req_wdata into data_readdata, register the result; go to RMW_WR.
  - At T+2: data_write=1, data_adress=latched index, data_writedata=merged word; go to IDLE.
  - resp_valid at T+3. busy high during T+1 and T+2.
- Latching: request fields are latched at accept. Changes on req_* while busy have no effect.
- resp_valid is high for exactly one cycle per accepted request and never without one.
- Address bits above WORD_IDX_W+1 are discarded; no wrap-around error is flagged.

Test Plan:
- Reset then word write/read: sw 0xDEADBEEF to addr 0x40 -> data_write=1, data_adress=0x10 at T, resp_valid at T+1. Then lw 0x40 -> resp_rdata=0xDEADBEEF, err=0 at T+2.
- Signed/unsigned byte loads: word at 0x40 = 0x80FF7F01.
  - lb 0x40 -> 0xFFFFFF80.
  - lbu 0x40 -> 0x00000080.
  - lb 0x42 -> 0x0000007F.
  - lh 0x42 -> 0x00007F01.
  - lhu 0x40 -> 0x000080FF.
- Sub-word store RMW: word at 0x40 = 0x11223344; sb 0xAA to 0x41 -> single write of 0x11AA3344 at T+2, busy high T+1..T+2, resp_valid at T+3. Then sh 0xBEEF to 0x42 -> word becomes 0x11AABEEF.
- Misalignment: lw 0x41, sh 0x43, size 11 at 0x40 -> each gives resp_err=1, resp_rdata=0 at T+1, with no data_write and memory unchanged.
- Busy handling: issue sb, hold a second lw on req during T+1..T+2 with different req_addr -> lw is not accepted until T+3, and the sb merge is unaffected by the changing req_addr.
- Reset mid-RMW: pull rst_n low during RMW_WAIT of sb to 0x40 -> no data_write occurs, memory word is unchanged, outputs are at reset values, busy=0 after release.
